display_scan_ndigit: RTL



---
 rtl/display_scan_ndigit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/display_scan_ndigit.sv
// Time-multiplexed seven-segment scanner for NUM_DIGITS hex digits on a
// common-anode board. It provides per-digit decimal points, a per-digit
// enable mask, leading-zero blanking and PWM brightness. Inputs are
// snapshotted once per frame, so a frame never shows a mix of old and new
// values.
module display_scan_ndigit #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 131072,
  parameter int PWM_BITS    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic                      blank_lz,
  input  logic [PWM_BITS-1:0]       brightness,
  output logic [7:0]                segments,
  output logic [NUM_DIGITS-1:0]     digitselect,
  output logic                      frame_start
);

  localparam int SLOT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PWM_STEP = REFRESH_DIV >> PWM_BITS;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Active-high a..g pattern for one hex nibble.
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    case (nib)
      4'h0: hex_font = 7'b1111110;
      4'h1: hex_font = 7'b0110000;
      4'h2: hex_font = 7'b1101101;
      4'h3: hex_font = 7'b1111001;
      4'h4: hex_font = 7'b0110011;
      4'h5: hex_font = 7'b1011011;
      4'h6: hex_font = 7'b1011111;
      4'h7: hex_font = 7'b1110000;
      4'h8: hex_font = 7'b1111111;
      4'h9: hex_font = 7'b1111011;
      4'hA: hex_font = 7'b1110111;
      4'hB: hex_font = 7'b0011111;
      4'hC: hex_font = 7'b1001110;
      4'hD: hex_font = 7'b0111101;
      4'hE: hex_font = 7'b1001111;
      default: hex_font = 7'b1000111;
    endcase
  endfunction

  logic [SLOT_W-1:0]         slot_q, slot_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   val_sh_q, val_sh_d;
  logic [NUM_DIGITS-1:0]     dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]     en_sh_q, en_sh_d;
  logic                      blz_sh_q, blz_sh_d;
  logic [PWM_BITS-1:0]       br_sh_q, br_sh_d;
  logic [7:0]                seg_q, seg_d;
  logic [NUM_DIGITS-1:0]     dsel_q, dsel_d;
  logic                      fs_q, fs_d;

  logic                      snap;
  logic [3:0]                nib;
  logic                      dp_bit;
  logic                      en_bit;
  logic                      upper_zero;
  logic                      zero_acc;
  logic [SLOT_W-1:0]         phase;
  logic                      pwm_on;
  logic                      blank;

  // Slot/digit counters and the frame snapshot; the snapshot value is
  // forwarded so the first slot of a frame already uses the new inputs.
  always_comb begin
    snap     = (slot_q == '0) && (idx_q == '0);
    val_sh_d = snap ? value      : val_sh_q;
    dp_sh_d  = snap ? dp         : dp_sh_q;
    en_sh_d  = snap ? digit_en   : en_sh_q;
    blz_sh_d = snap ? blank_lz   : blz_sh_q;
    br_sh_d  = snap ? brightness : br_sh_q;
    fs_d     = snap;
    slot_d   = slot_q + 1'b1;
    idx_d    = idx_q;
    if (slot_q == SLOT_LAST) begin
      slot_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Select the current digit's data and decide whether it is lit.
  always_comb begin
    nib        = 4'h0;
    dp_bit     = 1'b0;
    en_bit     = 1'b0;
    upper_zero = 1'b0;
    zero_acc   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_acc = zero_acc & (val_sh_d[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        nib        = val_sh_d[4*i +: 4];
        dp_bit     = dp_sh_d[i];
        en_bit     = en_sh_d[i];
        upper_zero = zero_acc;
      end
    end
    phase  = slot_q / SLOT_W'(PWM_STEP);
    pwm_on = phase < SLOT_W'(br_sh_d);
    blank  = !en_bit || !pwm_on || (blz_sh_d && (idx_q != '0) && upper_zero);
    seg_d  = 8'hFF;
    dsel_d = '1;
    if (!blank) begin
      seg_d = ~{hex_font(nib), dp_bit};
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dsel_d[i] = !(idx_q == IDX_W'(i));
      end
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= '0;
      idx_q    <= '0;
      val_sh_q <= '0;
      dp_sh_q  <= '0;
      en_sh_q  <= '0;
      blz_sh_q <= 1'b0;
      br_sh_q  <= '0;
      seg_q    <= 8'hFF;
      dsel_q   <= '1;
      fs_q     <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      idx_q    <= idx_d;
      val_sh_q <= val_sh_d;
      dp_sh_q  <= dp_sh_d;
      en_sh_q  <= en_sh_d;
      blz_sh_q <= blz_sh_d;
      br_sh_q  <= br_sh_d;
      seg_q    <= seg_d;
      dsel_q   <= dsel_d;
      fs_q     <= fs_d;
    end
  end

  assign segments    = seg_q;
  assign digitselect = dsel_q;
  assign frame_start = fs_q;

endmodule
